q_policy_walker: RTL and testbench

- Reader side of the Q-table produced by the Q-learning episode chain.
- Walks the learned greedy policy through the maze grid, from a start state to a target state.
- Reads Q(state, action) through a 1-cycle-latency read port and emits one action per step on a valid/ready stream.
- Reports whether the target was reached, or whether the walk aborted on the step limit.

---
 rtl/q_policy_walker.sv | 181 ++++++++++++++++++
 tb/tb_q_policy_walker.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_policy_walker.sv
// Greedy-policy walker over a Q-table: emits one argmax action per step until target or step limit.
// Optional Q_POLICY_LOOP_DETECT_EN adds a visited bitmap and a loop_abort output.
module q_policy_walker #(
  parameter int unsigned GRID_W    = 6,
  parameter int unsigned GRID_H    = 6,
  parameter int unsigned Q_W       = 32,
  parameter int unsigned MAX_STEPS = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [5:0]     start_state,
  input  logic [5:0]     target_state,
  output logic           q_rd_en,
  output logic [7:0]     q_rd_addr,
  input  logic [Q_W-1:0] q_rd_data,
  output logic           act_valid,
  input  logic           act_ready,
  output logic [1:0]     act_out,
  output logic [5:0]     act_state,
  output logic           busy,
  output logic           done,
  output logic           reached,
  output logic [6:0]     step_count
`ifdef Q_POLICY_LOOP_DETECT_EN
  ,
  output logic           loop_abort
`endif
);

  localparam int unsigned N_STATES = GRID_W * GRID_H;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_CMP, S_EMIT, S_DONE
  } state_t;

  state_t                 state, state_n;
  logic [5:0]             cur, tgt, nbr;
  logic [5:0]             cur_row, cur_col;
  logic [3:0]             mask;
  logic                   pend;
  logic [1:0]             pend_act;
  logic signed [Q_W-1:0]  best_val;
  logic [1:0]             best_act;
  logic                   best_vld;
  logic                   better;
  logic                   loop_hit;
  logic                   at_goal;
  logic                   at_limit;

`ifdef Q_POLICY_LOOP_DETECT_EN
  logic [N_STATES-1:0]    visited;
  assign loop_hit = visited[cur];
`else
  assign loop_hit = 1'b0;
`endif

  assign cur_row  = 6'(32'(cur) / GRID_W);
  assign cur_col  = 6'(32'(cur) % GRID_W);
  assign at_goal  = (cur == tgt);
  assign at_limit = (step_count == 7'(MAX_STEPS));

  // Moves that would leave the grid are never candidates
  always_comb begin
    mask    = 4'b0000;
    mask[0] = (cur_row == 6'd0);
    mask[1] = (cur_col == 6'(GRID_W - 1));
    mask[2] = (cur_row == 6'(GRID_H - 1));
    mask[3] = (cur_col == 6'd0);
  end

  // Strict greater-than keeps the lowest index on ties (actions arrive in ascending order)
  assign better = pend && !mask[pend_act] &&
                  (!best_vld || ($signed(q_rd_data) > best_val));

  always_comb begin
    nbr = cur;
    case (act_out)
      2'd0:    nbr = cur - 6'(GRID_W);
      2'd1:    nbr = cur + 6'd1;
      2'd2:    nbr = cur + 6'(GRID_W);
      default: nbr = cur - 6'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_CHECK;
      S_CHECK: begin
        if (at_goal || loop_hit || at_limit) state_n = S_DONE;
        else                                 state_n = S_FETCH;
      end
      S_FETCH: if (q_rd_addr[1:0] == 2'd3) state_n = S_CMP;
      S_CMP:   state_n = S_EMIT;
      S_EMIT:  if (act_ready) state_n = S_CHECK;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= '0;
      tgt        <= '0;
      q_rd_en    <= 1'b0;
      q_rd_addr  <= '0;
      pend       <= 1'b0;
      pend_act   <= '0;
      best_val   <= '0;
      best_act   <= '0;
      best_vld   <= 1'b0;
      act_valid  <= 1'b0;
      act_out    <= '0;
      act_state  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reached    <= 1'b0;
      step_count <= '0;
`ifdef Q_POLICY_LOOP_DETECT_EN
      visited    <= '0;
      loop_abort <= 1'b0;
`endif
    end else begin
      done     <= (state_n == S_DONE);
      q_rd_en  <= (state_n == S_FETCH);
      pend     <= q_rd_en;
      pend_act <= q_rd_addr[1:0];
      if (state_n == S_FETCH)
        q_rd_addr <= {cur, (state == S_FETCH) ? q_rd_addr[1:0] + 2'd1 : 2'd0};

      if (state == S_CHECK) begin
        best_vld <= 1'b0;
      end else if (better) begin
        best_vld <= 1'b1;
        best_val <= $signed(q_rd_data);
        best_act <= pend_act;
      end

      case (state)
        S_IDLE: if (start) begin
          cur        <= start_state;
          tgt        <= target_state;
          step_count <= '0;
          reached    <= 1'b0;
          busy       <= 1'b1;
`ifdef Q_POLICY_LOOP_DETECT_EN
          visited    <= '0;
          loop_abort <= 1'b0;
`endif
        end
        S_CHECK: begin
          if (at_goal) reached <= 1'b1;
`ifdef Q_POLICY_LOOP_DETECT_EN
          else if (loop_hit) loop_abort <= 1'b1;
          if (state_n == S_FETCH) visited[cur] <= 1'b1;
`endif
        end
        S_CMP: begin
          act_valid <= 1'b1;
          act_out   <= better ? pend_act : best_act;
          act_state <= cur;
        end
        S_EMIT: if (act_ready) begin
          act_valid <= 1'b0;
          cur       <= nbr;
          if (!at_limit) step_count <= step_count + 7'd1;
        end
        S_DONE:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q_policy_walker.sv
// Self-checking bench for q_policy_walker: Q-table memory model plus action scoreboard.
module tb_q_policy_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  start_state, target_state;
  logic        q_rd_en;
  logic [7:0]  q_rd_addr;
  logic [31:0] q_rd_data;
  logic        act_valid, act_ready;
  logic [1:0]  act_out;
  logic [5:0]  act_state;
  logic        busy, done, reached;
  logic [6:0]  step_count;
`ifdef Q_POLICY_LOOP_DETECT_EN
  logic        loop_abort;
`endif

  q_policy_walker dut (
    .clk(clk), .rst(rst), .start(start),
    .start_state(start_state), .target_state(target_state),
    .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
    .act_valid(act_valid), .act_ready(act_ready),
    .act_out(act_out), .act_state(act_state),
    .busy(busy), .done(done), .reached(reached), .step_count(step_count)
`ifdef Q_POLICY_LOOP_DETECT_EN
    , .loop_abort(loop_abort)
`endif
  );

  always #5 clk = ~clk;

  logic signed [31:0] qmem [0:255];
  logic [7:0]         exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;

  // One-cycle-latency Q-table read port
  always @(posedge clk) if (q_rd_en) q_rd_data <= qmem[q_rd_addr];
  always @(posedge clk) if (q_rd_en) rd_cnt <= rd_cnt + 1;
  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  // Scoreboard: every completed handshake must match the next expected {action, state}
  always @(negedge clk) begin
    if (act_valid && act_ready && !rst) begin
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL action_unexpected got act=%0d state=%0d, required no action", act_out, act_state);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({act_out, act_state} !== e) begin
          n_fail = n_fail + 1;
          $display("FAIL action_seq got act=%0d state=%0d, required act=%0d state=%0d",
                   act_out, act_state, e[7:6], e[5:0]);
        end
      end
    end
  end

  task automatic clear_q();
    for (int i = 0; i < 256; i++) qmem[i] = 32'sd0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic run_walk(input logic [5:0] s, input logic [5:0] t, input int budget, output bit ok);
    start_state = s; target_state = t; start = 1'b1;
    cycle();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; act_ready = 1'b1;
    start_state = '0; target_state = '0;
    clear_q();
    cycle(); cycle();
    n_checks++;
    if ({q_rd_en, act_valid, busy, done, reached, step_count, act_out, act_state, q_rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got en=%b v=%b busy=%b done=%b reached=%b steps=%0d act=%0d st=%0d addr=%0d, required all 0",
               q_rd_en, act_valid, busy, done, reached, step_count, act_out, act_state, q_rd_addr);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_trivial();
    int r0;
    clear_q();
    r0 = rd_cnt;
    start_state = 6'd14; target_state = 6'd14; start = 1'b1;
    cycle();
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++; $display("FAIL trivial_cycle1 got busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    cycle();
    n_checks++;
    if ({busy, done, reached} !== 3'b111) begin
      n_fail++; $display("FAIL trivial_done got busy=%b done=%b reached=%b, required 1 1 1", busy, done, reached);
    end
    n_checks++;
    if (step_count !== 7'd0) begin
      n_fail++; $display("FAIL trivial_steps got %0d, required 0", step_count);
    end
    cycle();
    n_checks++;
    if ({busy, done, reached} !== 3'b001) begin
      n_fail++; $display("FAIL trivial_after got busy=%b done=%b reached=%b, required 0 0 1", busy, done, reached);
    end
    n_checks++;
    if (rd_cnt !== r0) begin
      n_fail++; $display("FAIL trivial_reads got %0d reads, required 0", rd_cnt - r0);
    end
  endtask

  task automatic test_straight();
    bit ok;
    int d0;
    clear_q();
    for (int s = 0; s < 3; s++) begin
      qmem[s*4+1] = 32'sd100;
      exp_q.push_back({2'd1, 6'(s)});
    end
    d0 = done_cnt;
    run_walk(6'd0, 6'd3, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL straight_timeout got no done, required done"); end
    n_checks++;
    if ({reached, step_count} !== {1'b1, 7'd3}) begin
      n_fail++; $display("FAIL straight_result got reached=%b steps=%0d, required 1 3", reached, step_count);
    end
    cycle();
    n_checks++;
    if (exp_q.size() != 0 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL straight_drain got left=%0d pulses=%0d, required 0 1", exp_q.size(), done_cnt - d0);
    end
    exp_q.delete();
  endtask

  task automatic test_edge_mask();
    bit ok;
    clear_q();
    qmem[5*4+0] = 32'sd500; qmem[5*4+1] = 32'sd500;
    qmem[5*4+2] = -32'sd10; qmem[5*4+3] = -32'sd20;
    exp_q.push_back({2'd2, 6'd5});
    run_walk(6'd5, 6'd11, 100, ok);
    n_checks++;
    if (!ok || {reached, step_count} !== {1'b1, 7'd1} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL edge_top_right got ok=%b reached=%b steps=%0d left=%0d, required 1 1 1 0",
                         ok, reached, step_count, exp_q.size());
    end
    exp_q.delete();
    cycle();
    qmem[30*4+0] = 32'sd1;   qmem[30*4+1] = 32'sd2;
    qmem[30*4+2] = 32'sd900; qmem[30*4+3] = 32'sd900;
    exp_q.push_back({2'd1, 6'd30});
    run_walk(6'd30, 6'd31, 100, ok);
    n_checks++;
    if (!ok || {reached, step_count} !== {1'b1, 7'd1} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL edge_bottom_left got ok=%b reached=%b steps=%0d left=%0d, required 1 1 1 0",
                         ok, reached, step_count, exp_q.size());
    end
    exp_q.delete();
    cycle();
  endtask

  task automatic test_signed();
    bit ok;
    clear_q();
    qmem[14*4+0] = -32'sd5; qmem[14*4+1] = 32'sd3;
    qmem[14*4+2] = -32'sd1; qmem[14*4+3] = 32'sd2;
    exp_q.push_back({2'd1, 6'd14});
    run_walk(6'd14, 6'd15, 100, ok);
    n_checks++;
    if (!ok || {reached, step_count} !== {1'b1, 7'd1} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL signed_cmp got ok=%b reached=%b steps=%0d left=%0d, required 1 1 1 0",
                         ok, reached, step_count, exp_q.size());
    end
    exp_q.delete();
    cycle();
  endtask

  task automatic test_tie();
    bit ok;
    clear_q();
    for (int a = 0; a < 4; a++) qmem[7*4+a] = 32'sd42;
    exp_q.push_back({2'd0, 6'd7});
    run_walk(6'd7, 6'd1, 100, ok);
    n_checks++;
    if (!ok || {reached, step_count} !== {1'b1, 7'd1} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL tie_break got ok=%b reached=%b steps=%0d left=%0d, required 1 1 1 0",
                         ok, reached, step_count, exp_q.size());
    end
    exp_q.delete();
    cycle();
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_q();
    qmem[0*4+1] = 32'sd100;
    exp_q.push_back({2'd1, 6'd0});
    act_ready = 1'b0;
    start_state = 6'd0; target_state = 6'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (act_valid) begin ok = 1'b1; break; end
      cycle();
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_valid_timeout got act_valid=0, required 1"); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({act_valid, act_out, act_state, step_count} !== {1'b1, 2'd1, 6'd0, 7'd0}) begin
        n_fail++; $display("FAIL bp_hold cycle %0d got v=%b act=%0d st=%0d steps=%0d, required 1 1 0 0",
                           i, act_valid, act_out, act_state, step_count);
      end
      cycle();
    end
    act_ready = 1'b1;
    cycle();
    n_checks++;
    if ({act_valid, step_count} !== {1'b0, 7'd1}) begin
      n_fail++; $display("FAIL bp_accept got v=%b steps=%0d, required 0 1", act_valid, step_count);
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin ok = 1'b1; break; end
      cycle();
    end
    n_checks++;
    if (!ok || reached !== 1'b1 || step_count !== 7'd1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_end got ok=%b reached=%b steps=%0d left=%0d, required 1 1 1 0",
                         ok, reached, step_count, exp_q.size());
    end
    exp_q.delete();
    cycle();
  endtask

  task automatic test_loop();
    bit ok;
    int n_exp;
    clear_q();
    qmem[0*4+1] = 32'sd100;
    qmem[1*4+3] = 32'sd100;
`ifdef Q_POLICY_LOOP_DETECT_EN
    n_exp = 2;
`else
    n_exp = 64;
`endif
    for (int i = 0; i < n_exp; i++)
      exp_q.push_back((i % 2 == 0) ? {2'd1, 6'd0} : {2'd3, 6'd1});
    run_walk(6'd0, 6'd35, 1500, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL loop_timeout got no done, required done"); end
    n_checks++;
    if ({reached, step_count} !== {1'b0, 7'(n_exp)}) begin
      n_fail++; $display("FAIL loop_result got reached=%b steps=%0d, required 0 %0d", reached, step_count, n_exp);
    end
`ifdef Q_POLICY_LOOP_DETECT_EN
    n_checks++;
    if (loop_abort !== 1'b1) begin
      n_fail++; $display("FAIL loop_abort got %b, required 1", loop_abort);
    end
`endif
    cycle();
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL loop_drain got left=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midwalk();
    int d0;
    d0 = done_cnt;
    start_state = 6'd0; target_state = 6'd35; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle(); cycle();
    n_checks++;
    if ({busy, q_rd_en} !== 2'b11) begin
      n_fail++; $display("FAIL midwalk_fetching got busy=%b en=%b, required 1 1", busy, q_rd_en);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, q_rd_en, act_valid, step_count} !== '0) begin
      n_fail++; $display("FAIL midwalk_async got busy=%b en=%b v=%b steps=%0d, required 0", busy, q_rd_en, act_valid, step_count);
    end
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midwalk_no_done got pulses=%0d busy=%b, required 0 0", done_cnt - d0, busy);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_trivial();
    test_straight();
    test_edge_mask();
    test_signed();
    test_tie();
    test_backpressure();
    test_loop();
    test_reset_midwalk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
